// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM burst generator.
//   - Default widths for the period/duty counter, pulse counter and dead-time counter.
//   - Reset value of the latched period register (49.152 MHz / 246 ~= 200 kHz).
//   - Burst FSM state encoding.
package pwm_pkg;

    localparam int unsigned CNT_W_DEFAULT      = 12;
    localparam int unsigned PULSE_W_DEFAULT    = 28;
    localparam int unsigned DEAD_W_DEFAULT     = 8;
    localparam int unsigned DEF_PERIOD_DEFAULT = 245;

    typedef enum logic [1:0] {
        StIdle,
        StDead,
        StRun,
        StFin
    } state_e;

endpackage

// File: rtl/pwm_period_counter.sv
// Wrapping PWM period counter with duty compare.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   enable      - advance the counter this cycle
//   clear       - force the counter back to 0 (wins over enable)
//   period      - counter wraps to 0 after reaching this value
//   duty        - high while cnt < duty
//   high        - compare result for the current cnt
//   wrap        - strobe: counter is enabled and at its terminal value
module pwm_period_counter #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    output logic             high,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;

    assign wrap = enable && (cnt == period);
    // duty > period never matches a cnt value, so the leg stays high all period.
    assign high = (cnt < duty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_burst_gen.sv
// H-bridge PWM burst generator with programmable period, duty, pulse count,
// dead time and direction. One leg is modulated per burst, the other held low.
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   start        - one-cycle burst request, honoured only when idle
//   abort        - terminate the burst at the next edge, no done
//   dir          - 0: modulate pwm1, 1: modulate pwm2
//   period       - PWM period is period+1 clk cycles
//   duty         - high time in clk cycles
//   pulse_count  - PWM periods per burst
//   dead_time    - cycles with both legs low before the first pulse
//   pwm1, pwm2   - registered H-bridge gate drives
//   busy         - burst in progress
//   done         - one-cycle completion pulse
//   pulses_sent  - completed periods in the current/last burst
module pwm_burst_gen
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEFAULT,
    parameter int unsigned PULSE_W    = PULSE_W_DEFAULT,
    parameter int unsigned DEAD_W     = DEAD_W_DEFAULT,
    parameter int unsigned DEF_PERIOD = DEF_PERIOD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               dir,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   duty,
    input  logic [PULSE_W-1:0] pulse_count,
    input  logic [DEAD_W-1:0]  dead_time,
    output logic               pwm1,
    output logic               pwm2,
    output logic               busy,
    output logic               done,
    output logic [PULSE_W-1:0] pulses_sent
);

    state_e             state;
    logic [CNT_W-1:0]   period_l;
    logic [CNT_W-1:0]   duty_l;
    logic [PULSE_W-1:0] pulse_count_l;
    logic [DEAD_W-1:0]  dead_l;
    logic               dir_l;
    logic [DEAD_W-1:0]  dead_cnt;

    logic               cnt_enable;
    logic               cnt_high;
    logic               cnt_wrap;
    logic [PULSE_W-1:0] pulses_next;

    // The counter only runs in RUN; an abort freezes it so the aborting edge
    // cannot be mistaken for a wrap.
    assign cnt_enable  = (state == StRun) && !abort;
    assign pulses_next = pulses_sent + PULSE_W'(1);

    pwm_period_counter #(
        .CNT_W (CNT_W)
    ) u_period_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (cnt_enable),
        .clear  (!cnt_enable),
        .period (period_l),
        .duty   (duty_l),
        .high   (cnt_high),
        .wrap   (cnt_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            period_l      <= CNT_W'(DEF_PERIOD);
            duty_l        <= '0;
            pulse_count_l <= '0;
            dead_l        <= '0;
            dir_l         <= 1'b0;
            dead_cnt      <= '0;
            pwm1          <= 1'b0;
            pwm2          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pulses_sent   <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != StIdle)) begin
                // Abort beats both FIN and start; pulses_sent keeps the partial count.
                state <= StIdle;
                pwm1  <= 1'b0;
                pwm2  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        pwm1 <= 1'b0;
                        pwm2 <= 1'b0;
                        if (start && !abort) begin
                            period_l      <= period;
                            duty_l        <= duty;
                            pulse_count_l <= pulse_count;
                            dead_l        <= dead_time;
                            dir_l         <= dir;
                            dead_cnt      <= '0;
                            pulses_sent   <= '0;
                            busy          <= 1'b1;
                            if (dead_time != '0) begin
                                state <= StDead;
                            end else if (pulse_count == '0) begin
                                state <= StFin;
                            end else begin
                                state <= StRun;
                            end
                        end
                    end
                    StDead: begin
                        pwm1 <= 1'b0;
                        pwm2 <= 1'b0;
                        if (dead_cnt + DEAD_W'(1) == dead_l) begin
                            state <= (pulse_count_l == '0) ? StFin : StRun;
                        end else begin
                            dead_cnt <= dead_cnt + DEAD_W'(1);
                        end
                    end
                    StRun: begin
                        // Only the selected leg can ever be driven, so both-high is impossible.
                        pwm1 <= cnt_high && !dir_l;
                        pwm2 <= cnt_high && dir_l;
                        if (cnt_wrap) begin
                            pulses_sent <= pulses_next;
                            if (pulses_next == pulse_count_l) begin
                                state <= StFin;
                            end
                        end
                    end
                    StFin: begin
                        pwm1  <= 1'b0;
                        pwm2  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_burst_gen.sv
// Self-checking bench for pwm_burst_gen: directed bursts plus randomized bursts
// (random settings, aborts and mid-burst input changes) against an arithmetic
// reference model of the burst waveform.
module tb_pwm_burst_gen;
    import pwm_pkg::*;

    localparam int CNT_W   = 12;
    localparam int PULSE_W = 28;
    localparam int DEAD_W  = 8;

    typedef struct {
        int p;
        int d;
        int n;
        int t;
        bit dir;
    } cfg_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               abort;
    logic               dir;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   duty;
    logic [PULSE_W-1:0] pulse_count;
    logic [DEAD_W-1:0]  dead_time;
    logic               pwm1;
    logic               pwm2;
    logic               busy;
    logic               done;
    logic [PULSE_W-1:0] pulses_sent;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_burst_gen #(
        .CNT_W      (CNT_W),
        .PULSE_W    (PULSE_W),
        .DEAD_W     (DEAD_W),
        .DEF_PERIOD (245)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .dir         (dir),
        .period      (period),
        .duty        (duty),
        .pulse_count (pulse_count),
        .dead_time   (dead_time),
        .pwm1        (pwm1),
        .pwm2        (pwm2),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model. t is the number of clock edges after the accepting edge;
    // values describe the outputs just after edge t.
    function automatic int done_edge(cfg_t c);
        return c.t + c.n * (c.p + 1) + 1;
    endfunction

    function automatic int pulses_at(cfg_t c, int t);
        int k;
        if (t < c.t) return 0;
        k = (t - c.t) / (c.p + 1);
        return (k > c.n) ? c.n : k;
    endfunction

    function automatic bit active_at(cfg_t c, int t);
        if (c.n == 0 || t < c.t + 1 || t > c.t + c.n * (c.p + 1)) return 1'b0;
        return ((t - 1 - c.t) % (c.p + 1)) < c.d;
    endfunction

    task automatic check_outputs(input cfg_t c, input int t, input int abort_at);
        bit act;
        int exp_ps;
        bit exp_busy;
        bit exp_done;
        if (t == abort_at) begin
            act      = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_ps   = pulses_at(c, t - 1);
        end else begin
            act      = active_at(c, t);
            exp_busy = (t < done_edge(c));
            exp_done = (t == done_edge(c));
            exp_ps   = pulses_at(c, t);
        end
        check_eq("pwm1", 32'(pwm1), 32'(act && !c.dir));
        check_eq("pwm2", 32'(pwm2), 32'(act && c.dir));
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("pulses_sent", 32'(pulses_sent), 32'(exp_ps));
        check_eq("both_high", 32'(pwm1 & pwm2), 32'd0);
    endtask

    // Runs one burst from the accepting edge up to done (or the abort edge).
    // With disturb set, start and all settings are scrambled during the burst.
    task automatic run_burst(input cfg_t c, input int abort_at, input bit disturb);
        int last;
        last = (abort_at > 0) ? abort_at : done_edge(c);
        @(negedge clk);
        period      = CNT_W'(c.p);
        duty        = CNT_W'(c.d);
        pulse_count = PULSE_W'(c.n);
        dead_time   = DEAD_W'(c.t);
        dir         = c.dir;
        abort       = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_outputs(c, 0, abort_at);
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            abort = (t == abort_at);
            if (disturb) begin
                start       = 1'($urandom_range(0, 1));
                period      = CNT_W'($urandom);
                duty        = CNT_W'($urandom);
                pulse_count = PULSE_W'($urandom);
                dead_time   = DEAD_W'($urandom);
                dir         = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            check_outputs(c, t, abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_eq("idle_pwm", 32'({pwm1, pwm2}), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        cfg_t c;
        int   ab;
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        dir         = 1'b0;
        period      = '0;
        duty        = '0;
        pulse_count = '0;
        dead_time   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pwm", 32'({pwm1, pwm2}), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pulses", 32'(pulses_sent), 32'd0);
        check_eq("rst_period_l", 32'(dut.period_l), 32'd245);
        @(negedge clk);
        reset = 1'b0;
        idle_check(2);

        // Basic burst on pwm1, then dead time on pwm2
        c = '{p: 9, d: 3, n: 4, t: 0, dir: 1'b0};
        run_burst(c, -1, 1'b0);
        check_eq("t1_final_pulses", 32'(pulses_sent), 32'd4);
        c = '{p: 4, d: 2, n: 2, t: 5, dir: 1'b1};
        run_burst(c, -1, 1'b0);

        // Boundaries: duty 0, duty > period, pulse_count 0, period 0
        c = '{p: 9, d: 0, n: 3, t: 2, dir: 1'b0};
        run_burst(c, -1, 1'b0);
        c = '{p: 9, d: 20, n: 3, t: 0, dir: 1'b1};
        run_burst(c, -1, 1'b0);
        c = '{p: 9, d: 3, n: 0, t: 0, dir: 1'b0};
        run_burst(c, -1, 1'b0);
        c = '{p: 9, d: 3, n: 0, t: 3, dir: 1'b1};
        run_burst(c, -1, 1'b0);
        c = '{p: 0, d: 1, n: 5, t: 1, dir: 1'b0};
        run_burst(c, -1, 1'b0);

        // Abort in the third high phase
        c = '{p: 9, d: 5, n: 10, t: 0, dir: 1'b0};
        run_burst(c, 22, 1'b0);
        check_eq("abort_pulses", 32'(pulses_sent), 32'd2);
        idle_check(3);

        // Start/inputs scrambled mid-burst, then back-to-back bursts after done
        c = '{p: 7, d: 3, n: 3, t: 1, dir: 1'b0};
        run_burst(c, -1, 1'b1);
        c = '{p: 3, d: 1, n: 2, t: 0, dir: 1'b1};
        run_burst(c, -1, 1'b0);

        // Randomized bursts
        for (int i = 0; i < 40; i++) begin
            c.p   = $urandom_range(0, 15);
            c.d   = $urandom_range(0, 20);
            c.n   = $urandom_range(0, 5);
            c.t   = $urandom_range(0, 6);
            c.dir = 1'($urandom_range(0, 1));
            ab    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, done_edge(c)) : -1;
            run_burst(c, ab, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle_check($urandom_range(1, 3));
        end

        // Asynchronous reset with the leg high
        @(negedge clk);
        period      = 12'd9;
        duty        = 12'd5;
        pulse_count = 28'd10;
        dead_time   = 8'd0;
        dir         = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        check_eq("pre_rst_pwm2", 32'(pwm2), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_pwm", 32'({pwm1, pwm2}), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_pulses", 32'(pulses_sent), 32'd0);
        check_eq("arst_period_l", 32'(dut.period_l), 32'd245);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("arst_state", 32'(dut.state), 32'(StIdle));
        idle_check(2);
        c = '{p: 5, d: 2, n: 2, t: 2, dir: 1'b0};
        run_burst(c, -1, 1'b0);
        idle_check(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
